// File: rtl/mips_pipe_stage.sv
// Inter-stage pipeline register for the MIPS pipelines. It carries a NUM_FIELDS-word bundle
// under a valid/ready handshake, with optional two-entry skid buffering, flush and a stall counter.
module mips_pipe_stage #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 9,
    parameter int SKID       = 1,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    input  logic                         flush,
    output logic [1:0]                   occupancy,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int BUS_W = NUM_FIELDS * DATA_W;

    logic             main_valid;
    logic             skid_valid;
    logic [BUS_W-1:0] main_data;
    logic             accept;
    logic             main_free;

    // The main entry can take a new bundle when it is empty or is leaving this cycle.
    assign main_free = !main_valid || out_ready;
    assign accept    = in_valid && in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [BUS_W-1:0] skid_data;

            // in_ready comes straight from a flop, so no combinational path runs from out_ready.
            assign in_ready = !skid_valid;

            // NOTE: non-blocking assignments keep every register update reading pre-edge values.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (main_free) begin
                    if (skid_valid) begin
                        main_valid <= 1'b1;
                        skid_valid <= accept;
                    end else begin
                        main_valid <= accept;
                    end
                end else if (accept) begin
                    skid_valid <= 1'b1;
                end
            end

            // NOTE: payload registers are not reset; they are qualified by the valid bits and the output is masked.
            always_ff @(posedge clk) begin
                if (main_free) begin
                    if (skid_valid) begin
                        main_data <= skid_data;
                    end else if (accept) begin
                        main_data <= in_data;
                    end
                end
                if (accept && (skid_valid || !main_free)) begin
                    skid_data <= in_data;
                end
            end
        end else begin : g_single
            assign skid_valid = 1'b0;
            assign in_ready   = main_free;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    main_valid <= 1'b0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                end else if (out_ready) begin
                    main_valid <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    main_data <= in_data;
                end
            end
        end
    endgenerate

    // An empty stage presents an all-zero bundle, which decodes as a NOP.
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/mips_pipe_stage.md
# mips_pipe_stage

Parametrised pipeline stage register for the MIPS pipelines, superseding the fixed-field, always-advancing inter-stage registers. It carries a packed bundle of NUM_FIELDS words between two pipeline stages with a valid/ready handshake, synchronous flush, optional two-entry skid buffering, and a saturating stall counter. It sits between any two adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and inserts a zero bundle (IR = 0, i.e. `sll $0,$0,0` NOP) whenever it holds no valid instruction.

## Interface
- DATA_W, 32, width of one field in bits.
- NUM_FIELDS, 9, number of fields in the bundle; field k occupies bits [k*DATA_W +: DATA_W]; field 0 is IR by convention.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage presents a bundle.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_data  in  NUM_FIELDS*DATA_W  upstream bundle.
- out_valid  out  1  out_data holds a valid bundle.
- out_ready  in  1  downstream consumes the bundle this cycle; low = downstream stall.
- out_data  out  NUM_FIELDS*DATA_W  bundle to downstream; all-zero when out_valid = 0.
- flush  in  1  synchronous kill of all held and incoming bundles.
- occupancy  out  2  number of bundles held (0..2; never exceeds 1 when SKID = 0).
- stall_cnt  out  CNT_W  count of cycles with out_valid = 1 and out_ready = 0, saturating.

## Operation
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Storage: main entry (drives out_data) and, when SKID = 1, a skid entry; each has a valid bit.
- SKID = 0: in_ready = !main_valid | out_ready. On accept, main loads in_data; on consume without accept, main_valid clears.
- SKID = 1: in_ready = !skid_valid, registered.
  - main empty or consumed: main loads from skid if skid_valid (skid clears, or reloads from input on a same-cycle accept), otherwise from in_data on accept.
  - main valid and not consumed: an accept writes the skid entry.
  - Bundle order is strictly FIFO; no bundle is dropped or duplicated.
- out_data = main data when main_valid, else all zeros. Data registers of an invalid entry may hold stale values, but out_data is masked to zero.
- Flush has highest priority. In the cycle flush = 1, both valid bits clear at the next edge, any same-cycle accept is discarded, and in_ready is unaffected in that cycle. A consume in the flush cycle still counts as a transfer downstream.
- stall_cnt increments by 1 on each edge where out_valid & !out_ready is true, and holds at 2^CNT_W−1. It is not cleared by flush; only reset clears it.
- occupancy = main_valid + skid_valid.

## Timing
- Reset (reset = 0, asynchronous): out_valid = 0, out_data = 0, occupancy = 0, stall_cnt = 0, both valid bits = 0, in_ready = 1 (both modes, given out_ready irrelevant when empty). Deassertion is synchronised by the system; the first accept can occur on the first rising edge after deassertion.
- Latency: 1 cycle. A bundle accepted at edge N appears on out_data after edge N when the stage was empty.
- Throughput: 1 bundle/cycle in both modes while out_ready = 1.
- SKID = 1: after out_ready falls, exactly one more bundle is accepted, then in_ready drops at the next edge. in_ready rises the cycle after the skid entry drains.
- Reset mid-operation discards all held bundles immediately; outputs go to reset values without waiting for clk.

## Test plan
- Reset then stream: SKID = 1; hold reset = 0 while in_valid = 1; release and send IR = 0x8C010004, 0x00221820, 0xAC030008 with out_ready = 1 -> each appears 1 cycle later in order, occupancy = 1, stall_cnt = 0.
- Backpressure with skid: out_ready = 0 for 5 cycles while in_valid = 1 streams A, B, C -> A is held on out_data, B sits in skid, in_ready = 0 from the next cycle, C is not accepted, occupancy = 2, stall_cnt = 5. Then out_ready = 1 -> A, B, C delivered in order with no gap.
- Flush with full buffer: occupancy = 2, assert flush with in_valid = 1, D -> next cycle out_valid = 0, out_data = 0, occupancy = 0, and D is never output.
- SKID = 0 mode: out_ready = 0 with main valid -> in_ready = 0 combinationally in the same cycle. With out_ready = 1 and in_valid = 1 each cycle, back-to-back transfer occurs and occupancy never exceeds 1.
- Saturation: CNT_W = 4; stall 20 cycles -> stall_cnt = 15 and holds. Flush -> stall_cnt remains 15. Reset -> stall_cnt = 0.
- Asynchronous reset mid-stall: occupancy = 2, pull reset low between clock edges -> out_valid, occupancy, and out_data go to 0 before the next edge.
